// File: rtl/fb_depth_bram.sv
// fb_depth_bram: color/depth framebuffer in block RAM with a two-stage depth-tested write
// pipeline, a full-memory clear sequencer and a one-cycle-latency color read port.
module fb_depth_bram #(
    parameter int DATA_WIDTH = 12,
    parameter int Z_WIDTH = 16,
    parameter int ADDR_WIDTH = 17,
    parameter int DEPTH = 76800,
    parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '0,
    parameter logic [Z_WIDTH-1:0] CLEAR_Z = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  clear_done,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_color,
    input  logic [Z_WIDTH-1:0]    wr_z,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_color,
    output logic                  rd_valid,
    output logic [15:0]           fail_cnt
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2;

    logic [DATA_WIDTH-1:0] color_mem [DEPTH];
    logic [Z_WIDTH-1:0]    depth_mem [DEPTH];

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt, s1_addr;
    logic [DATA_WIDTH-1:0] s1_color, mem_color;
    logic [Z_WIDTH-1:0]    s1_z, s1_mz, fwd_z, mem_z;
    logic [IW-1:0]         mem_addr;
    logic                  s1_v, s1_inr, fwd_hit;
    logic                  accept, clearing, pass, fail, mem_we, wr_inr, rd_inr;

    assign wr_ready   = state == IDLE;
    assign busy       = state != IDLE;
    assign clearing   = state == CLEAR;
    assign clear_done = clearing && clr_cnt == LAST;
    assign accept     = wr_valid && wr_ready;
    assign wr_inr     = {1'b0, wr_addr} < DEPTH_W;
    assign rd_inr     = {1'b0, rd_addr} < DEPTH_W;
    // The depth read for a write issued right behind a committing write to the same
    // address sees stale memory, so the committed depth is substituted.
    assign pass       = s1_v && s1_inr && (s1_z < (fwd_hit ? fwd_z : s1_mz));
    assign fail       = s1_v && !pass;
    assign mem_we     = !rst && (clearing || pass);
    assign mem_addr   = clearing ? clr_cnt[IW-1:0] : s1_addr[IW-1:0];
    assign mem_color  = clearing ? CLEAR_COLOR : s1_color;
    assign mem_z      = clearing ? CLEAR_Z : s1_z;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            color_mem[mem_addr] <= mem_color;
            depth_mem[mem_addr] <= mem_z;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            s1_mz <= depth_mem[wr_addr[IW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_color <= '0;
        else if (rd_en)
            rd_color <= rd_inr ? color_mem[rd_addr[IW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            s1_v     <= 1'b0;
            fwd_hit  <= 1'b0;
            rd_valid <= 1'b0;
            fail_cnt <= '0;
        end else begin
            state    <= (state == IDLE && clear_start) ? DRAIN :
                        (state == DRAIN) ? CLEAR :
                        clear_done ? IDLE : state;
            clr_cnt  <= clearing ? clr_cnt + 1'b1 : '0;
            rd_valid <= rd_en;
            s1_v     <= accept;
            fwd_hit  <= pass && accept && wr_addr == s1_addr;
            fwd_z    <= s1_z;
            fail_cnt <= (wr_ready && clear_start) ? '0 :
                        (fail && fail_cnt != 16'hFFFF) ? fail_cnt + 16'd1 : fail_cnt;
            if (accept) begin
                s1_addr  <= wr_addr;
                s1_color <= wr_color;
                s1_z     <= wr_z;
                s1_inr   <= wr_inr;
            end
        end
    end
endmodule

// File: tb/tb_fb_depth_bram.sv
// tb_fb_depth_bram: directed scenarios against a behavioural framebuffer model, with a
// queue of expected read data compared as rd_valid returns.
module tb_fb_depth_bram;
    localparam int DW = 12, ZW = 16, AW = 5, D = 16;
    localparam logic [DW-1:0] CC = 12'h5A5;
    localparam logic [ZW-1:0] CZ = 16'hFFFF;

    logic clk = 0, rst = 1, clear_start = 0, busy, clear_done;
    logic wr_valid = 0, wr_ready, rd_en = 0, rd_valid;
    logic [AW-1:0] wr_addr = 0, rd_addr = 0;
    logic [DW-1:0] wr_color = 0, rd_color;
    logic [ZW-1:0] wr_z = 0;
    logic [15:0] fail_cnt;

    fb_depth_bram #(.DATA_WIDTH(DW), .Z_WIDTH(ZW), .ADDR_WIDTH(AW), .DEPTH(D),
                    .CLEAR_COLOR(CC), .CLEAR_Z(CZ)) dut (
        .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_color(wr_color),
        .wr_z(wr_z), .rd_en(rd_en), .rd_addr(rd_addr), .rd_color(rd_color),
        .rd_valid(rd_valid), .fail_cnt(fail_cnt));

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    logic [DW-1:0] m_color [D];
    logic [ZW-1:0] m_z [D];
    int m_fail = 0;
    logic [DW-1:0] exp_q [$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [ZW-1:0] z, input logic [DW-1:0] c);
        wr_valid = 1; wr_addr = AW'(a); wr_z = z; wr_color = c;
        if (a < D && z < m_z[a]) begin
            m_z[a] = z; m_color[a] = c;
        end else m_fail++;
        tick();
        wr_valid = 0;
    endtask

    task automatic settle();
        tick(); tick(); tick();
    endtask

    task automatic clear_mem();
        int n = 0;
        clear_start = 1;
        tick();
        clear_start = 0;
        while (busy && n < 100) begin tick(); n++; end
        total++;
        if (busy) $display("FAIL clear_timeout busy=%b required 0", busy); else passed++;
        for (int i = 0; i < D; i++) begin m_color[i] = CC; m_z[i] = CZ; end
        m_fail = 0;
    endtask

    task automatic test_readback(input string name);
        int n = 0;
        logic [DW-1:0] last;
        for (int a = D + 4; a >= 0; a--) begin
            if (a < D || a == D + 4) begin
                if (rd_valid) begin
                    last = exp_q.pop_front(); total++;
                    if (rd_color !== last) $display("FAIL %s rd_color=%h required %h", name, rd_color, last);
                    else passed++;
                end
                rd_en = 1; rd_addr = AW'(a);
                exp_q.push_back(a < D ? m_color[a] : '0);
                tick();
            end
        end
        rd_en = 0;
        while (exp_q.size() > 0 && n < 4) begin
            if (rd_valid) begin
                last = exp_q.pop_front(); total++;
                if (rd_color !== last) $display("FAIL %s rd_color=%h required %h", name, rd_color, last);
                else passed++;
            end
            tick(); n++;
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
        else passed++;
        exp_q.delete();
        total++;
        if (rd_valid !== 1'b0 || rd_color !== last)
            $display("FAIL %s_hold rd_valid=%b rd_color=%h required 0 %h", name, rd_valid, rd_color, last);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        total++;
        if ({busy, clear_done, rd_valid, rd_color, fail_cnt, wr_ready} !== {3'b000, 12'h0, 16'h0, 1'b1})
            $display("FAIL reset busy=%b done=%b rv=%b rc=%h fc=%h rdy=%b required 0 0 0 000 0000 1",
                     busy, clear_done, rd_valid, rd_color, fail_cnt, wr_ready);
        else passed++;
    endtask

    task automatic test_clear();
        int hi = 0, dn = 0, n = 0;
        clear_start = 1; tick(); clear_start = 0;
        total++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) $display("FAIL busy_rise busy=%b rdy=%b required 1 0", busy, wr_ready);
        else passed++;
        while (busy && n < 100) begin hi++; dn += clear_done; tick(); n++; end
        total++;
        if (hi != D + 1) $display("FAIL busy_cycles got=%0d required %0d", hi, D + 1); else passed++;
        total++;
        if (dn != 1) $display("FAIL clear_done_pulses got=%0d required 1", dn); else passed++;
        total++;
        if (fail_cnt !== 16'd0) $display("FAIL clear_fail_cnt got=%0d required 0", fail_cnt); else passed++;
        for (int i = 0; i < D; i++) begin m_color[i] = CC; m_z[i] = CZ; end
        m_fail = 0;
        test_readback("clear_read");
    endtask

    task automatic test_depth_reject();
        clear_mem();
        wr(5, 100, 12'hABC);
        wr(5, 200, 12'h123);
        settle();
        test_readback("depth_reject_read");
        total++;
        if (fail_cnt !== 16'(m_fail) || m_fail != 1) $display("FAIL depth_reject_fail_cnt got=%0d required 1", fail_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        clear_mem();
        wr_valid = 1;
        wr(7, 50, 12'h111); wr_valid = 1;
        wr(7, 40, 12'h222); wr_valid = 1;
        wr(7, 45, 12'h333);
        settle();
        test_readback("b2b_read");
        total++;
        if (fail_cnt !== 16'd1) $display("FAIL b2b_fail_cnt got=%0d required 1", fail_cnt); else passed++;
        total++;
        if (m_color[7] !== 12'h222) $display("FAIL b2b_model color=%h required 222", m_color[7]); else passed++;
    endtask

    task automatic test_boundary();
        clear_mem();
        wr(3, CZ, 12'h777);
        wr(20, 16'd1, 12'h888);
        wr(D - 1, CZ - 16'd1, 12'h999);
        settle();
        test_readback("boundary_read");
        total++;
        if (fail_cnt !== 16'd2) $display("FAIL boundary_fail_cnt got=%0d required 2", fail_cnt); else passed++;
    endtask

    task automatic test_clear_coincide();
        int n = 0;
        clear_mem();
        wr(0, 10, 12'h999);
        wr_valid = 1; wr_addr = 0; wr_z = 5; wr_color = 12'hEEE; clear_start = 1;
        tick();
        wr_valid = 0; clear_start = 0;
        while (busy && n < 100) begin tick(); n++; end
        for (int i = 0; i < D; i++) begin m_color[i] = CC; m_z[i] = CZ; end
        test_readback("coincide_read");
        total++;
        if (fail_cnt !== 16'd0) $display("FAIL coincide_fail_cnt got=%0d required 0", fail_cnt); else passed++;
    endtask

    task automatic test_reset_midclear();
        clear_mem();
        for (int i = 0; i < D; i++) begin wr_valid = 1; wr(i, ZW'(i + 1), DW'(12'h100 + i)); end
        wr(2, 16'd50, 12'hBAD);
        settle();
        clear_start = 1; tick(); clear_start = 0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1; tick(); rst = 0;
        total++;
        if (busy !== 1'b0 || fail_cnt !== 16'd0 || wr_ready !== 1'b1)
            $display("FAIL midclear_reset busy=%b fc=%0d rdy=%b required 0 0 1", busy, fail_cnt, wr_ready);
        else passed++;
        for (int i = 0; i < 8; i++) begin m_color[i] = CC; m_z[i] = CZ; end
        test_readback("midclear_read");
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin m_color[i] = 'x; m_z[i] = '0; end
        tick();
        test_reset();
        test_clear();
        test_depth_reject();
        test_back_to_back();
        test_boundary();
        test_clear_coincide();
        test_reset_midclear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
